// File: rtl/bus_decoder_fsm.sv
// bus_decoder_fsm: registered address decoder with a request/ready handshake
// between one master port and NUM_SLV slave ports.
//
// Each slave i owns the region (addr & SLV_MASK[i]) == SLV_BASE[i]; the lowest
// matching index wins. An accepted request latches target, direction, address and
// write data, then selects the slave until it returns ready or TIMEOUT cycles
// pass. The master sees a one-cycle m_ready pulse with m_rdata/m_err. Unmapped
// addresses answer immediately with m_err=1 and m_rdata=0.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   m_req, m_we                master request (sampled in IDLE) and write enable
//   m_addr, m_wdata            master address / write data
//   m_rdata, m_ready, m_err    response data, completion pulse, error flag
//   busy                       high while a transaction is in flight
//   s_cs, s_we, s_addr,        one-hot slave select and latched request
//   s_wdata
//   s_rdata, s_ready           packed per-slave read data and ready
//   err_addr, err_cnt          error log, present only with
//                              BUS_DECODER_ERR_LOG_EN defined
//
// Optional feature macro: BUS_DECODER_ERR_LOG_EN

module bus_decoder_fsm #(
  parameter int unsigned                 NUM_SLV  = 5,
  parameter int unsigned                 ADDR_W   = 32,
  parameter int unsigned                 DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = {32'hFFFF4000, 32'hFFFF3000, 32'hFFFF2000,
                                                     32'hFFFF1000, 32'h00000000},
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000,
                                                     32'hFFFFF000, 32'hFFFFE000},
  parameter int unsigned                 TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        m_req,
  input  logic                        m_we,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_wdata,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_ready,
  output logic                        m_err,
  output logic                        busy,
  output logic [NUM_SLV-1:0]          s_cs,
  output logic                        s_we,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic [NUM_SLV*DATA_W-1:0]   s_rdata,
  input  logic [NUM_SLV-1:0]          s_ready
`ifdef BUS_DECODER_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]           err_addr,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [NUM_SLV-1:0]  cs_onehot;

  // Region match; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign cs_onehot = NUM_SLV'(1) << idx_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          if (hit) begin
            idx_d   = hit_idx;
            we_d    = m_we;
            addr_d  = m_addr;
            wdata_d = m_wdata;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (s_ready[idx_q]) begin
          rdata_d = s_rdata[idx_q*DATA_W +: DATA_W];
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latched request, timeout counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    s_cs    = '0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      ST_ACCESS: begin
        s_cs = cs_onehot;
        busy = 1'b1;
      end
      ST_RESP: begin
        m_ready = 1'b1;
        m_err   = err_q;
        busy    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign m_rdata = rdata_q;
  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

`ifdef BUS_DECODER_ERR_LOG_EN
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [7:0]        err_cnt_q;

  // Request address is kept separately so decode misses can be logged too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_q <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && m_req) begin
        req_addr_q <= m_addr;
      end
      if (state_q == ST_RESP && err_q) begin
        err_addr_q <= req_addr_q;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`else
  // No error log in this build.
`endif

endmodule

// File: tb/tb_bus_decoder_fsm.sv
// Self-checking bench for bus_decoder_fsm: table-driven transactions plus
// hand-written reset-abort and overlapping-region sequences.
module tb_bus_decoder_fsm;

  localparam int unsigned NS = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            m_req, m_req2, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata, m_rdata2;
  logic            m_ready, m_ready2, m_err, m_err2, busy, busy2;
  logic [NS-1:0]   s_cs, s_cs2;
  logic            s_we, s_we2;
  logic [AW-1:0]   s_addr, s_addr2;
  logic [DW-1:0]   s_wdata, s_wdata2;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]   s_ready;
`ifdef BUS_DECODER_ERR_LOG_EN
  logic [AW-1:0]   err_addr, err_addr2;
  logic [7:0]      err_cnt, err_cnt2;
`endif

  always #5 clk = ~clk;

  bus_decoder_fsm #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .busy(busy), .s_cs(s_cs), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready)
`ifdef BUS_DECODER_ERR_LOG_EN
    , .err_addr(err_addr), .err_cnt(err_cnt)
`endif
  );

  // Slave 2 remapped on top of slave 0 to exercise priority.
  bus_decoder_fsm #(
    .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO),
    .SLV_BASE({32'hFFFF4000, 32'hFFFF3000, 32'h00000000, 32'hFFFF1000, 32'h00000000}),
    .SLV_MASK({32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFE000})
  ) u_dut2 (
    .clk(clk), .reset(reset), .m_req(m_req2), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata2), .m_ready(m_ready2), .m_err(m_err2),
    .busy(busy2), .s_cs(s_cs2), .s_we(s_we2), .s_addr(s_addr2), .s_wdata(s_wdata2),
    .s_rdata(s_rdata), .s_ready(s_ready)
`ifdef BUS_DECODER_ERR_LOG_EN
    , .err_addr(err_addr2), .err_cnt(err_cnt2)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          idx;      // expected slave, -1 for unmapped
    int          rdy_at;   // ACCESS cycle (1-based) with ready, 0 = never
    logic [31:0] sdata;    // read data presented by the target slave
    int          lat;      // cycles from request edge to m_ready
    int          cs_cyc;   // cycles with s_cs asserted
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_rd;
  logic        rd_known;
  int          exp_ecnt;
  logic [31:0] exp_eaddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log();
`ifdef BUS_DECODER_ERR_LOG_EN
    chk("err_cnt", 64'(err_cnt), 64'(exp_ecnt));
    chk("err_addr", 64'(err_addr), 64'(exp_eaddr));
`endif
  endtask

  task automatic run_txn(input vec_t v);
    logic [NS-1:0] oh;
    int            cyc;
    int            cs_cnt;
    logic          got;
    oh = (v.idx >= 0) ? (NS'(1) << v.idx) : '0;
    for (int i = 0; i < int'(NS); i++)
      s_rdata[i*DW +: DW] = (i == v.idx) ? v.sdata : (32'hA5A50000 | 32'(i));
    s_ready = '0;
    m_req   = 1'b1;
    m_we    = v.we;
    m_addr  = v.addr;
    m_wdata = v.wdata;
    step();
    // Master scribbles over its request while busy; must be ignored.
    m_req   = 1'b0;
    m_addr  = ~v.addr;
    m_wdata = ~v.wdata;
    m_we    = ~v.we;
    cyc = 1; cs_cnt = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      if (m_ready) begin
        got = 1'b1;
      end else begin
        chk("busy", 64'(busy), 64'd1);
        chk("m_err_idle", 64'(m_err), 64'd0);
        if (s_cs != '0) begin
          cs_cnt++;
          chk("s_cs", 64'(s_cs), 64'(oh));
          chk("s_addr", 64'(s_addr), 64'(v.addr));
          chk("s_we", 64'(s_we), 64'(v.we));
          if (v.we) chk("s_wdata", 64'(s_wdata), 64'(v.wdata));
          // Non-selected slaves claim ready to show they are ignored.
          s_ready = (cs_cnt == v.rdy_at) ? oh : ~oh;
        end
        step();
        cyc++;
      end
    end
    s_ready = '0;
    chk("m_ready_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc), 64'(v.lat));
    chk("cs_cycles", 64'(cs_cnt), 64'(v.cs_cyc));
    chk("m_err", 64'(m_err), 64'(v.err));
    if (v.chk_rd) chk("m_rdata", 64'(m_rdata), 64'(v.rdata));
    rd_known = v.chk_rd;
    last_rd  = v.rdata;
    if (v.err) begin
      if (exp_ecnt < 255) exp_ecnt++;
      exp_eaddr = v.addr;
    end
    step();
    chk("m_ready_pulse", 64'(m_ready), 64'd0);
    chk("m_err_cleared", 64'(m_err), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    if (rd_known) chk("m_rdata_hold", 64'(m_rdata), 64'(last_rd));
    check_log();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h00000010, 1'b0, 32'h0,  0,  1, 32'hDEADBEEF,  2,  1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{32'hFFFF3004, 1'b1, 32'h55, 3,  4, 32'h12345678,  5,  4, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{32'h80000000, 1'b0, 32'h0, -1,  0, 32'h0,         1,  0, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{32'hFFFF1000, 1'b0, 32'h0,  1,  0, 32'h11112222, 17, 16, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{32'hFFFF4FFC, 1'b0, 32'h0,  4,  2, 32'hCAFEF00D,  3,  2, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[5] = '{32'h00001FFC, 1'b0, 32'h0,  0,  1, 32'h01020304,  2,  1, 1'b0, 1'b1, 32'h01020304};
    vecs[6] = '{32'h00002000, 1'b0, 32'h0, -1,  0, 32'h0,         1,  0, 1'b1, 1'b1, 32'h0};
    vecs[7] = '{32'hFFFF2000, 1'b0, 32'h0,  2, 16, 32'h0BADC0DE, 17, 16, 1'b0, 1'b1, 32'h0BADC0DE};
    vecs[8] = '{32'hFFFF0FFC, 1'b0, 32'h0, -1,  0, 32'h0,         1,  0, 1'b1, 1'b1, 32'h0};

    reset = 1'b1; m_req = 1'b0; m_req2 = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; s_rdata = '0; s_ready = '0;
    exp_ecnt = 0; exp_eaddr = '0; rd_known = 1'b1; last_rd = '0;
    #12;
    chk("rst_s_cs", 64'(s_cs), 64'd0);
    chk("rst_s_we", 64'(s_we), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'd0);
    chk("rst_s_wdata", 64'(s_wdata), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    check_log();
    step();
    reset = 1'b0;
    step();

    for (int k = 0; k < 9; k++) run_txn(vecs[k]);

    // Reset on the second ACCESS cycle aborts the access without m_ready.
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'hFFFF1000; s_ready = '0;
    step();
    m_req = 1'b0;
    chk("abort_cs1", 64'(s_cs), 64'h02);
    step();
    chk("abort_cs2", 64'(s_cs), 64'h02);
    reset = 1'b1;
    #1;
    chk("abort_cs_drop", 64'(s_cs), 64'd0);
    chk("abort_busy_drop", 64'(busy), 64'd0);
    chk("abort_no_ready", 64'(m_ready), 64'd0);
    step();
    reset = 1'b0;
    exp_ecnt = 0; exp_eaddr = '0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_quiet", 64'(m_ready | busy), 64'd0);
      step();
    end
    check_log();
    run_txn(vecs[0]);

    // Overlapping regions: slave 0 and slave 2 both match, slave 0 wins.
    m_addr = 32'h00000100; m_we = 1'b0; s_ready = 5'b00001;
    s_rdata[0 +: DW] = 32'h600DF00D;
    m_req2 = 1'b1;
    step();
    m_req2 = 1'b0;
    chk("overlap_cs", 64'(s_cs2), 64'h01);
    step();
    chk("overlap_ready", 64'(m_ready2), 64'd1);
    chk("overlap_rdata", 64'(m_rdata2), 64'h600DF00D);
    chk("overlap_err", 64'(m_err2), 64'd0);
    s_ready = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_decoder_fsm.md
Name: bus_decoder_fsm

Overview:
- Parametrised, registered successor to the system address decoder: one master port fans out to NUM_SLV slave ports.
- Each slave region is defined by a (base, mask) pair.
- Adds a per-access request/ready handshake, latching of the decoded target, and error reporting for unmapped addresses and slave timeouts.
- Sits between the CPU data-memory port and the memory/GPIO/keypad/UART/SPI slaves.

Parameters:
- NUM_SLV, 5, number of slave ports.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SLV_BASE, {32'hFFFF4000,32'hFFFF3000,32'hFFFF2000,32'hFFFF1000,32'h00000000}, packed NUM_SLV*ADDR_W base table; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, {32'hFFFFF000,32'hFFFFF000,32'hFFFFF000,32'hFFFFF000,32'hFFFFE000}, packed mask table, same layout as SLV_BASE.
- TIMEOUT, 16, maximum number of ACCESS cycles to wait for slave ready; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  1  master request; sampled in IDLE only.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_W  master address.
- m_wdata  in  DATA_W  master write data.
- m_rdata  out  DATA_W  read data; valid when m_ready=1.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error flag, qualified by m_ready.
- busy  out  1  high whenever state != IDLE.
- s_cs  out  NUM_SLV  one-hot slave select.
- s_we  out  1  latched write enable.
- s_addr  out  ADDR_W  latched address.
- s_wdata  out  DATA_W  latched write data.
- s_rdata  in  NUM_SLV*DATA_W  packed slave read data; slave i at [i*DATA_W +: DATA_W].
- s_ready  in  NUM_SLV  per-slave ready.

Behaviour:
- Reset (asynchronous): state=IDLE; s_cs=0, s_we=0, s_addr=0, s_wdata=0, m_rdata=0, m_ready=0, m_err=0, busy=0, timeout counter=0, latched index=0.
- Match rule: slave i hits when (m_addr & MASK[i]) == BASE[i]. On multiple hits, the lowest index wins. The match is evaluated combinationally but used only in IDLE.
- State IDLE:
  - m_req=0: remain in IDLE.
  - m_req=1 and hit: latch index, m_we, m_addr and m_wdata; clear counter; go to ACCESS. s_cs is asserted one-hot from the next cycle.
  - m_req=1 and no hit: go to RESP with err=1, rdata=0. No s_cs is ever asserted.
- State ACCESS:
  - s_cs[idx]=1 for every ACCESS cycle; s_we, s_addr and s_wdata are held stable.
  - s_ready[idx]=1: capture s_rdata slice idx (capture on writes too; the value is don't-care); err=0; go to RESP.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 without ready: err=1, rdata=0, go to RESP.
  - Ready and timeout in the same cycle: ready wins, err=0.
  - s_ready of non-selected slaves is ignored.
- State RESP:
  - s_cs=0; m_ready=1 for exactly one cycle; m_rdata and m_err are valid in that cycle.
  - Next state is always IDLE. m_req is not sampled in RESP.
- Latency:
  - Hit with ready on the first ACCESS cycle: m_ready 2 cycles after the m_req sample edge.
  - Decode miss: m_ready 1 cycle after the m_req sample edge.
  - Timeout: m_ready TIMEOUT+1 cycles after the m_req sample edge.
- m_rdata is held from RESP until the next RESP; m_err is cleared to 0 outside RESP.
- The counter width is clog2(TIMEOUT)+1. Wrap-around is impossible because the FSM exits ACCESS at the limit.
- Reset asserted mid-ACCESS: s_cs drops immediately (asynchronous); no m_ready pulse is produced for the aborted access.
- Master changes to m_addr/m_wdata while busy=1 have no effect.

Optional Feature:
- Macro: BUS_DECODER_ERR_LOG_EN.
- Defined:
  - Adds output err_addr (ADDR_W), holding the latched address of the most recent erroring access. It is updated in the RESP cycle when err=1; reset value 0.
  - Adds output err_cnt (8 bits): increments once per error response and saturates at 8'hFF; reset value 0.
- Undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Read 0x00000010 with s_ready[0]=1 on the first ACCESS cycle and s_rdata slice0=0xDEADBEEF -> s_cs=5'b00001 for 1 cycle; m_ready 2 cycles after request; m_rdata=0xDEADBEEF; m_err=0.
- Write 0xFFFF3004 with data 0x55, s_ready[3] delayed 3 cycles -> s_cs=5'b01000 for 4 cycles; s_we=1; s_wdata=0x55; m_ready on the following cycle; m_err=0.
- Access to unmapped address 0x80000000 -> s_cs stays 0; m_ready 1 cycle after request; m_err=1; m_rdata=0; with the log macro, err_addr=0x80000000 and err_cnt=1.
- Access to 0xFFFF1000 with s_ready[1] held at 0 (TIMEOUT=16) -> s_cs[1] high for exactly 16 cycles; then m_ready=1, m_err=1, m_rdata=0.
- Overlap: SLV_BASE[2] remapped to 0x00000000 with mask 0xFFFFF000; access 0x00000100 -> slave 0 selected (lowest index wins).
- reset asserted on the second ACCESS cycle -> s_cs=0 and busy=0 immediately; no m_ready; the next request completes normally.
